// File: rtl/unpooler.sv
// Nearest-neighbour upsampler: replicates each pooled value into a
// POOL_SIZE x POOL_SIZE block, replaying one buffered row per vertical copy.
module unpooler #(
  parameter int FMAP_SIZE  = 4,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  master_rst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_op,
  output logic                  end_op
);

  localparam int W  = FMAP_SIZE / POOL_SIZE;
  localparam int HW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [HW-1:0] P_MAX = HW'(POOL_SIZE - 1);
  localparam logic [CW-1:0] W_MAX = CW'(W - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [HW-1:0] r_hx;
  logic [HW-1:0] r_vy;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [HW-1:0] w_hx_nx;
  logic [HW-1:0] w_vy_nx;
  logic [CW-1:0] w_col_nx;
  logic [CW-1:0] w_row_nx;

  logic [DATA_WIDTH-1:0] r_rowbuf [W];
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] w_pix;

  logic w_take;
  logic w_emit;
  logic w_end;
  logic w_hx_last;
  logic w_col_last;
  logic w_vy_last;
  logic w_row_last;

  assign in_ready = ce & (r_state == FILL) & (r_hx == '0) & ~master_rst;
  assign w_take   = in_ready & in_valid;

  assign w_hx_last  = (r_hx == P_MAX);
  assign w_col_last = (r_col == W_MAX);
  assign w_vy_last  = (r_vy == P_MAX);
  assign w_row_last = (r_row == W_MAX);

  // Only the first horizontal copy of a FILL row needs a fresh input.
  assign w_emit = ce & ((r_state == REPLAY) | (r_hx != '0) | in_valid);
  assign w_end  = w_emit & w_hx_last & w_col_last & w_vy_last & w_row_last;

  always_comb begin
    w_pix = r_hold;
    if (r_state == REPLAY) begin
      w_pix = r_rowbuf[r_col];
    end else if (r_hx == '0) begin
      w_pix = data_in;
    end
  end

  always_comb begin
    w_hx_nx    = r_hx;
    w_col_nx   = r_col;
    w_vy_nx    = r_vy;
    w_row_nx   = r_row;
    w_state_nx = r_state;
    if (w_emit) begin
      w_hx_nx = w_hx_last ? '0 : r_hx + 1'b1;
      if (w_hx_last) begin
        w_col_nx = w_col_last ? '0 : r_col + 1'b1;
        if (w_col_last) begin
          w_vy_nx    = w_vy_last ? '0 : r_vy + 1'b1;
          w_state_nx = w_vy_last ? FILL : REPLAY;
          if (w_vy_last) begin
            w_row_nx = w_row_last ? '0 : r_row + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      r_hx     <= '0;
      r_col    <= '0;
      r_vy     <= '0;
      r_row    <= '0;
      r_hold   <= '0;
      data_out <= '0;
      valid_op <= 1'b0;
      end_op   <= 1'b0;
    end else begin
      r_hx     <= w_hx_nx;
      r_col    <= w_col_nx;
      r_vy     <= w_vy_nx;
      r_row    <= w_row_nx;
      valid_op <= w_emit;
      end_op   <= w_end;
      if (w_take) begin
        r_hold <= data_in;
      end
      if (w_emit) begin
        data_out <= w_pix;
      end
    end
  end

  // Row buffer needs no reset: every slot is written before it is replayed.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_rowbuf[r_col] <= data_in;
    end
  end

endmodule

// File: doc/unpooler.md
# unpooler

Nearest-neighbour upsampler for the CNN datapath, the inverse of the pooling stage. It consumes a pooled feature map of (FMAP_SIZE/POOL_SIZE)² values in raster order and streams out the full-resolution FMAP_SIZE² map in raster order, replicating each input value into a POOL_SIZE×POOL_SIZE block. It sits between a pooled-map source and a full-resolution consumer (decoder/segmentation path). A one-row buffer of pooled values is replayed for the vertical repeats, so each input value is requested exactly once.

## Interface
- FMAP_SIZE, 4 — output (full-resolution) map rows/columns; must be a multiple of POOL_SIZE
- POOL_SIZE, 2 — replication factor per axis, ≥1
- DATA_WIDTH, 16 — data width
- Derived: W = FMAP_SIZE/POOL_SIZE (pooled row length = row-buffer depth)

Ports:
- clk  in  1  clock; all state updates on rising edge
- master_rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; 0 freezes the block
- data_in  in  DATA_WIDTH  pooled input value
- in_valid  in  1  data_in is valid
- in_ready  out  1  block accepts data_in this cycle (combinational)
- data_out  out  DATA_WIDTH  upsampled pixel (registered)
- valid_op  out  1  data_out carries a new pixel this cycle (registered)
- end_op  out  1  one-cycle pulse coincident with last pixel of a frame (registered)

## Operation
- Counters: hx (0..P-1 horizontal copy), col (0..W-1), vy (0..P-1 vertical copy), row (0..W-1). P = POOL_SIZE.
- States: FILL (vy=0: new values taken from input), REPLAY (vy≥1: values read from row buffer).
- in_ready = ce & (state==FILL) & (hx==0) & ~master_rst.
- Emission: a cycle emits one pixel when ce=1 and either (FILL, hx==0, in_valid&in_ready) or (FILL, hx>0) or (REPLAY). Accepted value is written to rowbuf[col] and a hold register; FILL hx>0 emits hold register; REPLAY emits rowbuf[col].
- On each emission: hx++; on hx wrap, col++; on col wrap, vy++ (FILL→REPLAY when vy becomes 1, if P>1); on vy wrap, row++ and state→FILL; on row wrap, frame ends and counters return to 0/FILL (next frame starts immediately).
- FILL with hx==0 and in_valid=0: bubble, no emission, no counter change.
- end_op set with the emission where row=W-1, vy=P-1, col=W-1, hx=P-1.
- P=1: pure registered pass-through; REPLAY never entered.
- Data is passed bit-exact; no arithmetic on data.

## Timing
- Reset (async): data_out=0, valid_op=0, end_op=0, all counters 0, state FILL; in_ready=0 while master_rst high, =ce after release. Row buffer contents undefined (never read before written).
- Latency: value accepted at edge k appears on data_out with valid_op=1 immediately after edge k (1 register stage).
- Throughput: one pixel per ce cycle when in_valid held high; input accepted once every P cycles during FILL rows, not at all during REPLAY rows.
- ce=0 at an edge: valid_op and end_op register 0; counters, state, data_out, row buffer hold; in_ready=0. No pixel is duplicated or dropped across ce gaps.
- in_valid dropping during FILL hx>0 has no effect (held value emitted).
- Reset mid-frame: frame abandoned, restart at pixel 0 awaiting new first input; no end_op.

## Test plan
- FMAP_SIZE=4,P=2, inputs A,B,C,D, in_valid=1,ce=1 continuously -> data_out A A B B A A B B C C D D C C D D over 16 consecutive valid_op cycles; in_ready high at cycles 0,2,8,10 only; end_op high only with 16th pixel.
- Same, in_valid low for 3 cycles when B is due -> valid_op low exactly 3 cycles after second A, then B B; no extra A; sequence otherwise identical.
- ce low for 4 cycles during REPLAY of row 0 -> valid_op 0, data_out held for those cycles; resumes at next pixel; total 16 valid pixels.
- Two back-to-back frames (A..D then E..H) -> 32 pixels, end_op at pixels 16 and 32, E accepted the cycle after D's last copy emitted.
- master_rst asserted after 6 pixels -> outputs 0 asynchronously; new frame W,X,Y,Z yields correct 16-pixel map, single end_op.
- P=1, FMAP_SIZE=3, inputs 1..9 -> data_out 1..9 one cycle after each acceptance, end_op with 9.
